// File: rtl/pcm_frame_buffer.sv
// Stereo-to-mono downmix into ping-pong frame banks, streamed out over valid/ready.
// Each frame is FRAME_LEN samples and its final beat carries out_last.
module pcm_frame_buffer #(
  parameter  int DW        = 24,
  parameter  int FRAME_LEN = 64,
  localparam int AW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] right,
  input  logic          newsample_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          overflow
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  state_t          r_state, w_state_nxt;
  logic            r_nv_q;
  logic            r_overflow;
  logic [1:0]      r_bank_full, w_bank_full_nxt;
  logic            r_wr_bank, r_rd_bank;
  logic [AW-1:0]   r_wr_idx, r_rd_idx;
  logic [DW-1:0]   r_mem [2][FRAME_LEN];

  logic               w_se, w_wr_en, w_wr_done, w_fire, w_rd_done;
  logic signed [DW:0] w_sum;
  logic [DW-1:0]      w_mono;

  // One extra bit makes the sum exact; the arithmetic shift floors toward -inf.
  assign w_sum  = $signed({left[DW-1], left}) + $signed({right[DW-1], right});
  assign w_mono = DW'(w_sum >>> 1);

  assign w_se      = newsample_valid & ~r_nv_q;
  assign w_wr_en   = w_se & ~r_bank_full[r_wr_bank];
  assign w_wr_done = w_wr_en & (r_wr_idx == LAST_IDX);
  assign w_fire    = out_valid & out_ready;
  assign w_rd_done = w_fire & out_last;
  assign overflow  = r_overflow;

  // Writer and reader always own different banks, so set and clear never collide.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_done) w_bank_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_bank_full_nxt[r_rd_bank] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_nv_q      <= 1'b0;
      r_overflow  <= 1'b0;
      r_bank_full <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_nv_q      <= newsample_valid;
      r_bank_full <= w_bank_full_nxt;

      if (w_se && r_bank_full[r_wr_bank]) begin
        r_overflow <= 1'b1;
      end else if (w_wr_en) begin
        if (r_wr_idx == LAST_IDX) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end

      if (r_state == S_IDLE && r_bank_full[r_rd_bank]) begin
        r_rd_idx <= '0;
      end else if (w_fire) begin
        if (out_last) r_rd_bank <= ~r_rd_bank;
        else          r_rd_idx  <= r_rd_idx + 1'b1;
      end
    end
  end

  // NOTE: the sample store is left unreset; bank_full gates every read, so stale
  // contents are never visible, and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_bank][r_wr_idx] <= w_mono;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (r_bank_full[r_rd_bank]) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = r_mem[r_rd_bank][r_rd_idx];
        out_last  = (r_rd_idx == LAST_IDX);
        if (out_ready && out_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Bench for pcm_frame_buffer: a frame-queue model of the buffer is checked every cycle,
// alongside directed scenarios with hand-computed expectations.
module tb_pcm_frame_buffer;
  localparam int DW = 24;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] left = '0, right = '0;
  logic          newsample_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, overflow;

  pcm_frame_buffer #(.DW(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .newsample_valid(newsample_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mono value from the arithmetic definition: floor of the true average.
  function automatic logic [DW-1:0] mono_of(logic [DW-1:0] l, logic [DW-1:0] r);
    int s, h;
    s = int'($signed(l)) + int'($signed(r));
    h = s / 2;
    if (s < 0 && (s % 2) != 0) h = h - 1;
    return h[DW-1:0];
  endfunction

  // Model: completed frames awaiting output (flattened), plus the frame being collected.
  logic [DW-1:0] m_frames[$];
  logic [DW-1:0] m_part[$];
  int            m_held = 0, m_rd_pos = 0, idle_run = 0;
  bit            m_prev_nv = 0, m_ovf = 0;
  bit            prev_stall = 0, prev_last_fire = 0, prev_last_val = 0;
  logic [DW-1:0] prev_data = '0;

  logic [DW-1:0] cap_d[$];
  bit            cap_l[$];
  int            cap_c[$];

  always @(negedge clk) begin
    bit ev, fire, exp_last;
    int held_before;
    if (reset) begin
      m_frames.delete(); m_part.delete();
      m_held = 0; m_rd_pos = 0; idle_run = 0;
      m_prev_nv = 0; m_ovf = 0;
      prev_stall = 0; prev_last_fire = 0;
    end else begin
      check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      if (prev_last_fire) check("bubble_after_last", {31'b0, out_valid}, 32'd0);
      if (prev_stall) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", {31'b0, out_last}, {31'b0, prev_last_val});
      end
      exp_last = (m_rd_pos == FL - 1);
      if (out_valid) begin
        idle_run = 0;
        check("valid_needs_frame", {31'b0, out_valid}, {31'b0, m_frames.size() != 0});
        if (m_frames.size() != 0) begin
          check("out_data", 32'(out_data), 32'(m_frames[0]));
          check("out_last", {31'b0, out_last}, {31'b0, exp_last});
        end
      end else if (m_frames.size() != 0) begin
        idle_run++;
        check("idle_with_frame_ready", 32'(idle_run > 1), 32'd0);
      end else begin
        idle_run = 0;
      end

      fire           = out_valid & out_ready;
      prev_stall     = out_valid & ~out_ready;
      prev_data      = out_data;
      prev_last_val  = out_last;
      prev_last_fire = fire & exp_last;

      ev          = newsample_valid & ~m_prev_nv;
      m_prev_nv   = newsample_valid;
      held_before = m_held;

      if (fire) begin
        cap_d.push_back(out_data); cap_l.push_back(out_last); cap_c.push_back(cyc);
        if (m_frames.size() != 0) begin
          void'(m_frames.pop_front());
          m_rd_pos++;
          if (m_rd_pos == FL) begin
            m_rd_pos = 0;
            m_held--;
          end
        end
      end

      if (ev) begin
        if (held_before == 2) begin
          m_ovf = 1;
        end else begin
          m_part.push_back(mono_of(left, right));
          if (m_part.size() == FL) begin
            foreach (m_part[i]) m_frames.push_back(m_part[i]);
            m_part.delete();
            m_held++;
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [DW-1:0] l, logic [DW-1:0] r);
    left = l; right = r; newsample_valid = 1'b1;
    tick(1);
    newsample_valid = 1'b0;
    tick(1);
  endtask

  task automatic clear_caps();
    cap_d.delete(); cap_l.delete(); cap_c.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v5[4];
    logic [DW-1:0] l5, r5;
    logic [DW-1:0] v6[4];

    // 1. Reset with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      left = DW'($urandom); right = DW'($urandom);
      newsample_valid = 1'($urandom); out_ready = 1'($urandom);
    end
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_last", {31'b0, out_last}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    reset = 1'b0; newsample_valid = 1'b0; out_ready = 1'b1;
    tick(2);

    // Literal pins of the model's downmix
    check("pin_mono_a", 32'(mono_of(24'hFFFFFF, 24'h000000)), 32'h00FFFFFF);
    check("pin_mono_b", 32'(mono_of(24'h800000, 24'h800000)), 32'h00800000);
    check("pin_mono_c", 32'(mono_of(24'h7FFFFF, 24'h7FFFFF)), 32'h007FFFFF);
    check("pin_mono_d", 32'(mono_of(24'h000003, 24'h000000)), 32'h00000001);

    // 2. Basic frame and latency
    clear_caps();
    repeat (3) send(24'h000100, 24'h000300);
    left = 24'h000100; right = 24'h000300; newsample_valid = 1'b1;
    tick(1);
    newsample_valid = 1'b0;
    check("t2_valid_t1", {31'b0, out_valid}, 32'd0);
    tick(1);
    check("t2_valid_t2", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t2_beat_valid", {31'b0, out_valid}, 32'd1);
      check("t2_beat_data", 32'(out_data), 32'h00000200);
      check("t2_beat_last", {31'b0, out_last}, 32'(i == 3));
      tick(1);
    end
    check("t2_bubble", {31'b0, out_valid}, 32'd0);
    check("t2_beats", 32'(cap_d.size()), 32'd4);

    // 3. Rounding
    clear_caps();
    send(24'hFFFFFF, 24'h000000);
    send(24'h800000, 24'h800000);
    send(24'h7FFFFF, 24'h7FFFFF);
    send(24'h000003, 24'h000000);
    tick(8);
    check("t3_count", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() == 4) begin
      check("t3_r0", 32'(cap_d[0]), 32'h00FFFFFF);
      check("t3_r1", 32'(cap_d[1]), 32'h00800000);
      check("t3_r2", 32'(cap_d[2]), 32'h007FFFFF);
      check("t3_r3", 32'(cap_d[3]), 32'h00000001);
      check("t3_last", {31'b0, cap_l[3]}, 32'd1);
    end

    // 4. Overflow with both banks full
    clear_caps();
    out_ready = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      send(DW'(n), DW'(n));
      if (n == 8) check("t4_ovf_before", {31'b0, overflow}, 32'd0);
      if (n == 9) check("t4_ovf_after", {31'b0, overflow}, 32'd1);
    end
    out_ready = 1'b1;
    tick(15);
    check("t4_count", 32'(cap_d.size()), 32'd8);
    if (cap_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t4_data", 32'(cap_d[i]), 32'(i + 1));
        check("t4_last", {31'b0, cap_l[i]}, 32'(i == 3 || i == 7));
      end
      check("t4_gap", 32'(cap_c[4] - cap_c[3]), 32'd2);
      check("t4_contig", 32'(cap_c[1] - cap_c[0]), 32'd1);
    end
    check("t4_ovf_sticky", {31'b0, overflow}, 32'd1);

    // 5. Held level counts once; random backpressure
    clear_caps();
    for (int k = 0; k < 4; k++) begin
      l5 = DW'($urandom); r5 = DW'($urandom);
      v5[k] = mono_of(l5, r5);
      left = l5; right = r5; newsample_valid = 1'b1;
      repeat (10) begin
        out_ready = 1'($urandom);
        tick(1);
      end
      newsample_valid = 1'b0;
      out_ready = 1'($urandom);
      tick(1);
    end
    repeat (30) begin
      out_ready = 1'($urandom);
      tick(1);
    end
    out_ready = 1'b1;
    tick(10);
    check("t5_count", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() == 4)
      for (int i = 0; i < 4; i++) check("t5_data", 32'(cap_d[i]), 32'(v5[i]));

    // Random traffic, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      if (!newsample_valid) begin
        left = DW'($urandom); right = DW'($urandom);
      end
      newsample_valid = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    newsample_valid = 1'b0; out_ready = 1'b1;
    tick(30);

    // 6. Reset mid-stream
    reset = 1'b1; tick(1); reset = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(DW'(24'h000010 + k), DW'(24'h000010 + k));
    for (int i = 0; i < 20 && !out_valid; i++) tick(1);
    check("t6_valid_seen", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0; reset = 1'b1;
    tick(1);
    check("t6_valid_after_rst", {31'b0, out_valid}, 32'd0);
    check("t6_ovf_after_rst", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    clear_caps();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v6[k] = DW'(24'h000A00 + 2 * k);
      send(v6[k], v6[k]);
    end
    tick(8);
    check("t6_count", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t6_data", 32'(cap_d[i]), 32'(v6[i]));
      check("t6_last", {31'b0, cap_l[3]}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
